// File: rtl/spi_pkg.sv
// Shared SPI-stack definitions: sequencer and SPI main state encodings, mode constants.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP,
        S_ERROR
    } spi_seq_state_t;

    typedef enum logic [2:0] {
        M_IDLE,
        M_CMD,
        M_ADDR,
        M_DATA,
        M_DONE
    } spi_main_state_t;

    localparam logic SPI_MODE_READ  = 1'b0;
    localparam logic SPI_MODE_WRITE = 1'b1;

endpackage

// File: rtl/spi_seq_if.sv
// System-side command and response streams of the SPI register-access sequencer.
interface spi_seq_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_last;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_len, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_len, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
    );
endinterface

// File: rtl/spi_seq_watchdog.sv
// Loadable down-counter; expire flags the last enabled cycle before reaching zero.
module spi_seq_watchdog #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = en && (cnt == CNT_W'(1));
endmodule

// File: rtl/spi_seq.sv
// SPI register-access sequencer: single writes and burst reads issued one at a time to the SPI main.
// Optional completion watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_seq
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_WIDTH      = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_seq_if.slave              sys,
    output logic                  spi_en,
    output logic                  spi_mode,
    output logic [ADDR_WIDTH-1:0] spi_addr,
    output logic [DATA_WIDTH-1:0] spi_wdata,
    output logic                  spi_wvalid,
    input  logic [DATA_WIDTH-1:0] spi_rdata,
    input  logic                  spi_rvalid,
    output logic                  busy,
    output logic                  err
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    spi_seq_state_t        state, state_nxt;
    logic                  rvalid_q, done, accept, rsp_hs, wd_expire, more_q;
    logic [GAP_W-1:0]      gap_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remain_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;
    logic                  rsp_last_q;

    assign accept = (state == S_IDLE) && sys.cmd_valid;
    assign rsp_hs = (state == S_RESP) && sys.rsp_ready;
    // Only a fresh rising edge of spi_rvalid counts; a level left over from before is ignored.
    assign done   = spi_rvalid && !rvalid_q;

    assign sys.cmd_ready = (state == S_IDLE);
    assign sys.rsp_valid = (state == S_RESP);
    assign sys.rsp_data  = rsp_data_q;
    assign sys.rsp_addr  = rsp_addr_q;
    assign sys.rsp_last  = rsp_last_q;
    assign spi_en        = (state == S_ISSUE);
    assign spi_wvalid    = spi_en && (spi_mode == SPI_MODE_WRITE);
    assign busy          = (state != S_IDLE);

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    spi_seq_watchdog #(.CNT_W(WD_W)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == S_ISSUE),
        .en       (state == S_WAIT),
        .load_val (WD_W'(TIMEOUT_CYCLES)),
        .expire   (wd_expire)
    );
    assign err = (state == S_ERROR);
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sys.cmd_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done)
                    state_nxt = (spi_mode == SPI_MODE_WRITE) ? S_GAP : S_RESP;
                else if (wd_expire)
                    state_nxt = S_ERROR;
            end
            S_RESP:  if (sys.rsp_ready) state_nxt = S_GAP;
            S_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1))
                    state_nxt = more_q ? S_ISSUE : S_IDLE;
            end
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage boundary: control state and every visible output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rvalid_q   <= 1'b0;
            gap_cnt    <= '0;
            more_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_last_q <= 1'b0;
            spi_mode   <= SPI_MODE_READ;
            spi_addr   <= '0;
            spi_wdata  <= '0;
        end else begin
            state    <= state_nxt;
            rvalid_q <= spi_rvalid;
            gap_cnt  <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (accept) begin
                more_q    <= 1'b0;
                spi_mode  <= sys.cmd_write;
                spi_addr  <= sys.cmd_addr;
                spi_wdata <= sys.cmd_data;
            end
            if (state == S_WAIT && done && spi_mode == SPI_MODE_READ) begin
                rsp_data_q <= spi_rdata;
                rsp_addr_q <= addr_q;
                rsp_last_q <= (remain_q == '0);
            end
            if (rsp_hs)
                more_q <= (remain_q != '0);
            // spi_addr stays frozen through the gap; the next beat's address lands on re-issue
            if (state == S_GAP && state_nxt == S_ISSUE)
                spi_addr <= addr_q;
        end
    end

    // Stage boundary: burst walk (address and remaining count), no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= sys.cmd_addr;
            remain_q <= sys.cmd_write ? '0 : sys.cmd_len;
        end else if (rsp_hs && remain_q != '0) begin
            remain_q <= remain_q - LEN_WIDTH'(1);
            addr_q   <= addr_q + ADDR_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_spi_seq.sv
// Scoreboard bench for spi_seq with a behavioural SPI main responder.
module tb_spi_seq;
    localparam int AW = 6, DW = 8, LW = 4, GAP = 2, TMO = 64;

    typedef struct { logic [DW-1:0] d; logic [AW-1:0] a; logic l; } rsp_t;
    typedef struct { logic m; logic [AW-1:0] a; logic [DW-1:0] d; } spi_t;

    logic clk = 1'b0, rst = 1'b1;
    logic spi_en, spi_mode, spi_wvalid, spi_rvalid, busy, err;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdata, spi_rdata;

    int n_tests = 0, n_fail = 0;
    int lat = 3, seq = 0;
    logic stuck = 1'b0;
    rsp_t exp_rsp[$];
    spi_t exp_spi[$];

    spi_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) sif ();

    spi_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
              .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .sys(sif.slave),
        .spi_en(spi_en), .spi_mode(spi_mode), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_wvalid(spi_wvalid), .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI main responder: clears completion on spi_en, raises it lat cycles later
    initial begin : spi_main_model
        int cnt;
        logic is_rd;
        cnt = 0; is_rd = 1'b0;
        spi_rvalid = 1'b0; spi_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                spi_rvalid = 1'b0; cnt = 0;
            end else if (spi_en) begin
                spi_rvalid = 1'b0; cnt = lat; is_rd = !spi_mode;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !stuck) begin
                    spi_rvalid = 1'b1;
                    if (is_rd) begin
                        spi_rdata = DW'(seq); seq++;
                    end
                end
            end
        end
    end

    initial begin : monitor
        spi_t es;
        rsp_t er;
        forever begin
            @(negedge clk);
            if (!rst && spi_en) begin
                if (exp_spi.size() == 0) check("spi_unexpected", 32'(1), 32'(0));
                else begin
                    es = exp_spi.pop_front();
                    check("spi_mode", 32'(spi_mode), 32'(es.m));
                    check("spi_addr", 32'(spi_addr), 32'(es.a));
                    check("spi_wvalid", 32'(spi_wvalid), 32'(es.m));
                    if (es.m) check("spi_wdata", 32'(spi_wdata), 32'(es.d));
                end
            end
            if (!rst && sif.rsp_valid && sif.rsp_ready) begin
                if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
                else begin
                    er = exp_rsp.pop_front();
                    check("rsp_data", 32'(sif.rsp_data), 32'(er.d));
                    check("rsp_addr", 32'(sif.rsp_addr), 32'(er.a));
                    check("rsp_last", 32'(sif.rsp_last), 32'(er.l));
                end
            end
        end
    end

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [LW-1:0] l);
        int k;
        @(posedge clk); #1;
        sif.cmd_write = w; sif.cmd_addr = a; sif.cmd_data = d; sif.cmd_len = l;
        sif.cmd_valid = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (sif.cmd_ready) break;
            k++;
            if (k > 2000) begin check("cmd_accept_timeout", 32'(0), 32'(1)); break; end
        end
        @(posedge clk); #1;
        sif.cmd_valid = 1'b0;
        @(negedge clk);
        check("spi_en_after_accept", 32'(spi_en), 32'(1));
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (cycles > 2000) begin check("idle_timeout", 32'(0), 32'(1)); break; end
        end
    endtask

    task automatic push_burst(input logic [AW-1:0] a, input int n, input int s0);
        for (int i = 0; i <= n; i++) begin
            exp_spi.push_back('{m: 1'b0, a: AW'(a + AW'(i)), d: '0});
            exp_rsp.push_back('{d: DW'(s0 + i), a: AW'(a + AW'(i)), l: (i == n)});
        end
    endtask

    initial begin : stimulus
        int cyc, k, n_en, n_chg, bad;
        logic [DW-1:0] d0;
        sif.cmd_valid = 1'b0; sif.cmd_write = 1'b0; sif.cmd_addr = '0;
        sif.cmd_data = '0; sif.cmd_len = '0; sif.rsp_ready = 1'b1;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(sif.cmd_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp_valid", 32'(sif.rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(sif.rsp_data), 32'(0));
        check("rst_rsp_addr", 32'(sif.rsp_addr), 32'(0));
        check("rst_rsp_last", 32'(sif.rsp_last), 32'(0));
        check("rst_spi_en", 32'(spi_en), 32'(0));
        check("rst_spi_mode", 32'(spi_mode), 32'(0));
        check("rst_spi_addr", 32'(spi_addr), 32'(0));
        check("rst_spi_wdata", 32'(spi_wdata), 32'(0));
        check("rst_spi_wvalid", 32'(spi_wvalid), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        @(posedge clk); #1 rst = 1'b0;

        // single write: ISSUE + 3 wait + 2 gap cycles busy
        exp_spi.push_back('{m: 1'b1, a: 6'h12, d: 8'hA5});
        send_cmd(1'b1, 6'h12, 8'hA5, 4'd0);
        wait_idle(cyc);
        check("write_busy_cycles", 32'(cyc + 1), 32'(6));

        // burst read wrapping 0x3F -> 0x00
        seq = 'h10;
        push_burst(6'h3E, 3, 'h10);
        send_cmd(1'b0, 6'h3E, 8'h00, 4'd3);
        wait_idle(cyc);

        // response backpressure for 20 cycles after beat 1
        seq = 'h20;
        push_burst(6'h05, 1, 'h20);
        sif.rsp_ready = 1'b0;
        send_cmd(1'b0, 6'h05, 8'h00, 4'd1);
        k = 0;
        while (!sif.rsp_valid && k < 200) begin @(negedge clk); k++; end
        check("stall_rsp_valid", 32'(sif.rsp_valid), 32'(1));
        d0 = sif.rsp_data; n_en = 0; n_chg = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_en) n_en++;
            if (sif.rsp_data !== d0 || !sif.rsp_valid) n_chg++;
        end
        check("stall_no_spi_en", 32'(n_en), 32'(0));
        check("stall_rsp_stable", 32'(n_chg), 32'(0));
        @(posedge clk); #1 sif.rsp_ready = 1'b1;
        @(negedge clk);
        k = 0;
        forever begin
            @(negedge clk);
            if (spi_en || k > 100) break;
            k++;
        end
        check("gap_after_handshake", 32'(k), 32'(GAP));
        wait_idle(cyc);

        // command held during a burst waits for idle
        seq = 'h30;
        push_burst(6'h20, 2, 'h30);
        exp_spi.push_back('{m: 1'b1, a: 6'h21, d: 8'h5A});
        send_cmd(1'b0, 6'h20, 8'h00, 4'd2);
        @(posedge clk); #1;
        sif.cmd_write = 1'b1; sif.cmd_addr = 6'h21; sif.cmd_data = 8'h5A; sif.cmd_valid = 1'b1;
        bad = 0; k = 0;
        forever begin
            @(negedge clk);
            if (!busy || k > 2000) break;
            if (sif.cmd_ready) bad++;
            k++;
        end
        check("held_cmd_ready_low", 32'(bad), 32'(0));
        check("held_first_idle_ready", 32'(sif.cmd_ready), 32'(1));
        @(negedge clk);
        check("held_second_issue", 32'(spi_en), 32'(1));
        @(posedge clk); #1 sif.cmd_valid = 1'b0;
        wait_idle(cyc);
        check("queues_drained_mid", 32'(exp_rsp.size()), 32'(0));

        // reset while waiting for completion
        lat = 10;
        exp_spi.push_back('{m: 1'b1, a: 6'h33, d: 8'h77});
        send_cmd(1'b1, 6'h33, 8'h77, 4'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_cmd_ready", 32'(sif.cmd_ready), 32'(1));
        check("midrst_spi_mode", 32'(spi_mode), 32'(0));
        check("midrst_spi_addr", 32'(spi_addr), 32'(0));
        check("midrst_spi_wdata", 32'(spi_wdata), 32'(0));
        check("midrst_spi_en", 32'(spi_en), 32'(0));
        @(posedge clk); #1 rst = 1'b0; lat = 3;
        exp_spi.push_back('{m: 1'b1, a: 6'h0C, d: 8'hC3});
        send_cmd(1'b1, 6'h0C, 8'hC3, 4'd0);
        wait_idle(cyc);
        check("postrst_busy_cycles", 32'(cyc + 1), 32'(6));

`ifdef SPI_SEQ_TIMEOUT_EN
        // watchdog: completion never arrives
        stuck = 1'b1;
        exp_spi.push_back('{m: 1'b0, a: 6'h08, d: 8'h00});
        send_cmd(1'b0, 6'h08, 8'h00, 4'd0);
        k = 1;
        forever begin
            @(negedge clk);
            if (err || k > 500) break;
            k++;
        end
        check("timeout_err_cycle", 32'(k), 32'(1 + TMO));
        repeat (5) @(negedge clk);
        check("timeout_err_sticky", 32'(err), 32'(1));
        check("timeout_cmd_ready", 32'(sif.cmd_ready), 32'(0));
        @(posedge clk); #1 rst = 1'b1; stuck = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
`endif
        @(negedge clk);
        check("final_err", 32'(err), 32'(0));
        check("spi_queue_empty", 32'(exp_spi.size()), 32'(0));
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_seq.md
# spi_seq

Register-access sequencer sitting directly upstream of the SPI main in the SPI interface stack. Accepts single-write and burst-read commands from a system-side valid/ready port and issues them to the SPI main one transaction at a time. It pulses its enable and drives mode/address/data, detects transaction completion, and returns read data on a backpressured response stream. It enforces an inter-transaction gap and, optionally, a completion watchdog.

## Interface
- ADDR_WIDTH, 6: register address width; matches the SPI main.
- DATA_WIDTH, 8: register data width; matches the SPI main.
- LEN_WIDTH, 4: burst length field width.
- GAP_CYCLES, 2: idle cycles between consecutive SPI transactions; must be ≥1.
- TIMEOUT_CYCLES, 64: watchdog limit in clk cycles; used only with the watchdog macro.

Ports:
- clk  in  1  system clock; same clock as the SPI main.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = single write; 0 = burst read.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_data  in  DATA_WIDTH  write data; ignored for reads.
- cmd_len  in  LEN_WIDTH  reads: transfer count minus 1; ignored for writes.
- rsp_valid  out  1  read result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_addr  out  ADDR_WIDTH  address the data came from.
- rsp_last  out  1  final beat of the burst.
- spi_en  out  1  one-cycle start pulse to the SPI main.
- spi_mode  out  1  1 = write, 0 = read.
- spi_addr  out  ADDR_WIDTH  transaction address.
- spi_wdata  out  DATA_WIDTH  write data.
- spi_wvalid  out  1  write data valid.
- spi_rdata  in  DATA_WIDTH  SPI main read data.
- spi_rvalid  in  1  SPI main completion flag:
  - cleared by the SPI main when it accepts spi_en;
  - set by the SPI main at the end of every transaction.
- busy  out  1  high in any state other than S_IDLE.
- err  out  1  sticky watchdog error.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP, S_ERROR.
- **S_IDLE**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch the command: write flag, address, data, and remaining count (cmd_len for reads, 0 for writes).
  - Then go to S_ISSUE.
- **S_ISSUE**
  - spi_en=1 for exactly this one cycle.
  - spi_wvalid=spi_mode.
  - Next state: S_WAIT.
- **S_WAIT**
  - Completion is spi_rvalid & ~rvalid_q, where rvalid_q is spi_rvalid registered every cycle.
  - Write completes: go to S_GAP.
  - Read completes: capture spi_rdata into rsp_data and the current address into rsp_addr. Set rsp_last = (remaining==0). Go to S_RESP.
- **S_RESP**
  - rsp_valid=1; rsp_data, rsp_addr and rsp_last are held stable until rsp_ready.
  - On rsp_ready: if remaining≠0, decrement remaining and increment the address; then go to S_GAP.
- **S_GAP**
  - Count GAP_CYCLES cycles.
  - Then go to S_ISSUE if burst beats remain, otherwise S_IDLE.
- **S_ERROR**: terminal until rst.
- spi_mode, spi_addr and spi_wdata are registered and held constant from S_ISSUE through the end of S_GAP.
- Address increments modulo 2^ADDR_WIDTH; 63 wraps to 0.
- A burst has at most 2^LEN_WIDTH beats (cmd_len=15 gives 16 reads).

## Timing
- Reset values:
  - state S_IDLE, so cmd_ready=1 and busy=0.
  - All other outputs 0: rsp_valid, rsp_data, rsp_addr, rsp_last, spi_en, spi_mode, spi_addr, spi_wdata, spi_wvalid, err.
- Command accepted at edge T gives spi_en high in cycle T+1.
- A completion edge at cycle C gives rsp_valid high from C+1.
- Response backpressure stalls the next SPI transaction; no read is ever dropped.
- cmd_ready is low whenever busy=1; commands offered while busy wait.
- With rsp_valid and rsp_ready both high in the same cycle, the beat completes that cycle.
- Reset asserted mid-transaction aborts immediately; the SPI main is reset by the same rst.
- spi_rvalid already high when S_WAIT is entered is not a completion; only a fresh rising edge counts.

## Configuration
- SPI_SEQ_TIMEOUT_EN defined:
  - A counter runs in S_WAIT and is cleared on entry.
  - Reaching TIMEOUT_CYCLES without completion moves to S_ERROR and sets err=1.
  - err stays set until rst.
- SPI_SEQ_TIMEOUT_EN undefined:
  - No counter is built; S_WAIT waits indefinitely.
  - err is tied to 0 and S_ERROR is unreachable.

## Structure
- Shared package spi_pkg holds:
  - spi_seq_state_t;
  - the existing SPI main state enum;
  - the SPI_MODE_READ/SPI_MODE_WRITE constants (0/1).
- Sub-module spi_seq_watchdog: a loadable down-counter with a clear input and an expire output. It is instantiated only under SPI_SEQ_TIMEOUT_EN.

## Test plan
- Write cmd, addr=0x12, data=0xA5 → one spi_en pulse with spi_mode=1, spi_addr=0x12, spi_wdata=0xA5; no rsp_valid; back to idle after completion + GAP_CYCLES.
- Read burst, addr=0x3E, cmd_len=3, model returns 0x10,0x11,0x12,0x13:
  - four responses with rsp_addr 0x3E, 0x3F, 0x00, 0x01;
  - rsp_last only on the 4th beat.
- Burst with rsp_ready held low 20 cycles after beat 1 → no spi_en during the stall; rsp_data stable; beat 2 issued GAP_CYCLES after the handshake.
- cmd_valid held during a burst → cmd_ready=0 until idle; second command accepted the first idle cycle.
- rst pulsed while in S_WAIT → all outputs at their reset values the same cycle; next command runs normally.
- SPI_SEQ_TIMEOUT_EN with spi_rvalid stuck low → err=1 exactly TIMEOUT_CYCLES after entering S_WAIT; cmd_ready stays 0 until rst.
